// File: rtl/exe_mem_req.sv
// exe_mem_req: issues execute-stage loads/stores to the data SRAM, tracks up to
// DEPTH outstanding requests in a small FIFO, and returns extended load data
// (or a store acknowledgement) one cycle after each data_ok. Responses belonging
// to requests issued before a flush are silently dropped.
module exe_mem_req #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_block,
  input  logic        flush,
  output logic        ale,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_is_store,
  output logic        busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FIFO entry layout: [5] we, [4:3] size, [2] unsigned, [1:0] addr offset
  logic [5:0]       r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_cancel_cnt;
  logic             r_resp_valid;
  logic [31:0]      r_resp_data;
  logic             r_resp_is_store;

  logic             w_ale;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic             w_resp;
  logic [CNT_W-1:0] w_count_nxt;
  logic [5:0]       w_head;
  logic [31:0]      w_shifted;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_data;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata;

  assign w_ale = in_valid & (((in_size == 2'b01) & in_addr[0]) |
                             ((in_size == 2'b10) & (in_addr[1:0] != 2'b00)));
  // Never request during a flush so nothing new enters behind the cancellation.
  assign w_req  = in_valid & ~w_ale & ~in_block & ~flush & (r_count < FULL_CNT);
  assign w_push = w_req & data_sram_addr_ok;
  assign w_pop  = data_sram_data_ok & (r_count != '0);
  assign w_resp = w_pop & (r_cancel_cnt == '0);

  assign ale             = w_ale;
  assign data_sram_req   = w_req;
  assign data_sram_wr    = in_we;
  assign data_sram_size  = in_size;
  assign data_sram_addr  = in_addr;
  assign data_sram_wstrb = w_wstrb;
  assign data_sram_wdata = w_wdata;
  // Blocked or misaligned ops retire without touching memory.
  assign in_ready        = w_push | (in_valid & (w_ale | in_block)) | flush;
  assign busy            = (r_count != '0);
  assign resp_valid      = r_resp_valid;
  assign resp_data       = r_resp_data;
  assign resp_is_store   = r_resp_is_store;

  // Store byte enables and lane-replicated write data.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = in_wdata;
    unique case (in_size)
      2'b00: begin
        w_wdata = {4{in_wdata[7:0]}};
        w_wstrb = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{in_wdata[15:0]}};
        w_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: w_wstrb = 4'b1111;
    endcase
    if (!in_we) w_wstrb = 4'b0000;
  end

  // Extract and extend load data using the head entry's saved attributes.
  always_comb begin
    w_head      = r_fifo[r_rd_ptr];
    w_shifted   = data_sram_rdata >> {w_head[1:0], 3'b000};
    w_byte      = w_shifted[7:0];
    w_half      = w_head[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    w_load_data = data_sram_rdata;
    unique case (w_head[4:3])
      2'b00:   w_load_data = {{24{~w_head[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{~w_head[2] & w_half[15]}}, w_half};
      default: w_load_data = data_sram_rdata;
    endcase
    if (w_head[5]) w_load_data = 32'h0;
  end

  // Outstanding-count next state: push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) w_count_nxt = r_count + CNT_W'(1);
    if (w_pop && !w_push) w_count_nxt = r_count - CNT_W'(1);
  end

  // FIFO payload storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {in_we, in_size, in_unsigned, in_addr[1:0]};
  end

  // Control state: pointers, counters and the registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_cancel_cnt    <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= 32'h0;
      r_resp_is_store <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      // Everything still outstanding after this cycle's pop is stale after a flush.
      if (flush) begin
        r_cancel_cnt <= r_count - CNT_W'(w_pop);
      end else if (w_pop && (r_cancel_cnt != '0)) begin
        r_cancel_cnt <= r_cancel_cnt - CNT_W'(1);
      end
      r_resp_valid <= w_resp;
      if (w_resp) begin
        r_resp_data     <= w_load_data;
        r_resp_is_store <= w_head[5];
      end
    end
  end

endmodule

// File: tb/tb_exe_mem_req.sv
// Testbench for exe_mem_req: directed scenarios plus randomized traffic, checked
// by a queue-based reference model and a decoupled response monitor.
module tb_exe_mem_req;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_we = 1'b0;
  logic [1:0]  in_size = 2'b00;
  logic        in_unsigned = 1'b0;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_wdata = 32'h0;
  logic        in_block = 1'b0;
  logic        flush = 1'b0;
  logic        ale;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0;
  logic        data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_is_store;
  logic        busy;

  exe_mem_req #(.DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_block(in_block), .flush(flush), .ale(ale),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_is_store(resp_is_store), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_resp = 0;
  logic [31:0] last_data = 32'h0;
  logic        last_store = 1'b0;

  typedef struct {bit we; bit [1:0] size; bit uns; bit [1:0] off; bit cancelled;} ent_t;
  typedef struct {bit st; bit [31:0] data;} rsp_t;
  ent_t out_q[$];
  rsp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference rules computed from the bench's own view of the outstanding ops.
  function automatic bit f_ale();
    return in_valid && ((in_size == 2'd1 && in_addr[0]) ||
                        (in_size == 2'd2 && in_addr[1:0] != 2'd0));
  endfunction

  function automatic bit f_req();
    return in_valid && !f_ale() && !in_block && !flush && (out_q.size() < DEPTH);
  endfunction

  function automatic bit f_ready();
    return (f_req() && data_sram_addr_ok) || (in_valid && (f_ale() || in_block)) || flush;
  endfunction

  function automatic logic [3:0] f_wstrb();
    if (!in_we) return 4'h0;
    case (in_size)
      2'd0:    return 4'(1 << in_addr[1:0]);
      2'd1:    return in_addr[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata();
    case (in_size)
      2'd0:    return {4{in_wdata[7:0]}};
      2'd1:    return {2{in_wdata[15:0]}};
      default: return in_wdata;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input ent_t e, input logic [31:0] rd);
    logic [31:0] v;
    if (e.we) return 32'h0;
    case (e.size)
      2'd0: begin
        v = (rd >> (8 * e.off)) & 32'hFF;
        if (!e.uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (rd >> (16 * e.off[1])) & 32'hFFFF;
        if (!e.uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // Model update on each active edge: accept, complete, cancel, reset.
  always @(posedge clk) begin : model
    bit   push;
    bit   pop;
    ent_t e;
    push = f_req() && data_sram_addr_ok;
    pop  = data_sram_data_ok && (out_q.size() > 0);
    if (reset) begin
      out_q.delete();
    end else begin
      if (pop) begin
        e = out_q.pop_front();
        if (!e.cancelled) exp_q.push_back('{st: e.we, data: f_load(e, data_sram_rdata)});
      end
      if (flush) foreach (out_q[i]) out_q[i].cancelled = 1'b1;
      if (push) out_q.push_back('{we: in_we, size: in_size, uns: in_unsigned,
                                  off: in_addr[1:0], cancelled: 1'b0});
    end
  end

  // Monitor on the falling edge: combinational outputs and responses.
  always @(negedge clk) begin : monitor
    rsp_t r;
    chk("ale", ale, f_ale());
    chk("req", data_sram_req, f_req());
    chk("in_ready", in_ready, f_ready());
    chk("busy", busy, out_q.size() != 0);
    if (f_req()) begin
      chk("sram_wr", data_sram_wr, in_we);
      chk("sram_size", data_sram_size, in_size);
      chk("sram_addr", data_sram_addr, in_addr);
      chk("sram_wdata", data_sram_wdata, f_wdata());
      chk("sram_wstrb", data_sram_wstrb, f_wstrb());
    end
    chk("resp_valid", resp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      if (resp_valid) begin
        chk("resp_data", resp_data, r.data);
        chk("resp_is_store", resp_is_store, r.st);
      end
    end
    if (resp_valid) begin
      n_resp++;
      last_data  = resp_data;
      last_store = resp_is_store;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_block = 1'b0; flush = 1'b0; reset = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
  endtask

  task automatic op(input bit we, input bit [1:0] sz, input bit uns,
                    input bit [31:0] a, input bit [31:0] wd);
    in_valid = 1'b1; in_we = we; in_size = sz; in_unsigned = uns;
    in_addr = a; in_wdata = wd;
  endtask

  initial begin : stim
    int          n0;
    logic [31:0] a;
    repeat (3) step();
    idle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_is_store", resp_is_store, 1'b0);

    // Signed byte load at an odd offset.
    op(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0); data_sram_addr_ok = 1'b1;
    #1 chk("ldb_wstrb", data_sram_wstrb, 4'h0);
    step(); idle(); step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80AA_BBCC;
    step(); idle(); step();
    chk("ldb_data", last_data, 32'hFFFF_FF80);
    chk("ldb_is_store", last_store, 1'b0);

    // Upper-half store.
    op(1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_5678); data_sram_addr_ok = 1'b1;
    #1 chk("sth_wdata", data_sram_wdata, 32'h5678_5678);
    chk("sth_wstrb", data_sram_wstrb, 4'hC);
    step(); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    step(); idle(); step();
    chk("sth_is_store", last_store, 1'b1);
    chk("sth_data", last_data, 32'h0);

    // Misaligned word load retires with ale and no request.
    op(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0); data_sram_addr_ok = 1'b1;
    #1 chk("mis_ale", ale, 1'b1);
    chk("mis_req", data_sram_req, 1'b0);
    chk("mis_ready", in_ready, 1'b1);
    n0 = n_resp;
    step(); idle(); step(); step();
    chk("mis_no_resp", n_resp, n0);

    // Full FIFO holds off requests; push and pop together.
    op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0); data_sram_addr_ok = 1'b1; step();
    op(1'b0, 2'd2, 1'b0, 32'h14, 32'h0); step();
    op(1'b0, 2'd2, 1'b0, 32'h18, 32'h0);
    #1 chk("full_req", data_sram_req, 1'b0);
    chk("full_busy", busy, 1'b1);
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111; step();
    data_sram_rdata = 32'h2222_2222; step();
    data_sram_data_ok = 1'b0; step();
    op(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0);
    #1 chk("full_again_req", data_sram_req, 1'b0);
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333; step();
    data_sram_rdata = 32'h4444_4444; step();
    idle(); step();

    // Flush cancels two outstanding loads; a later load responds normally.
    op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0); data_sram_addr_ok = 1'b1; step();
    op(1'b0, 2'd2, 1'b0, 32'h24, 32'h0); step();
    idle(); flush = 1'b1; step();
    idle(); n0 = n_resp;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555; step(); step();
    idle(); step(); step();
    chk("flush_no_resp", n_resp, n0);
    op(1'b0, 2'd1, 1'b1, 32'h26, 32'h0); data_sram_addr_ok = 1'b1; step();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_1234; step();
    idle(); step();
    chk("post_flush_data", last_data, 32'h0000_8001);
    chk("post_flush_resp", n_resp, n0 + 1);

    // Reset with one outstanding discards it.
    op(1'b0, 2'd2, 1'b0, 32'h30, 32'h0); data_sram_addr_ok = 1'b1; step();
    idle(); reset = 1'b1; n0 = n_resp; step();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h6666_6666; step();
    idle(); step();
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_no_resp", n_resp, n0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      in_valid    = ($urandom_range(0, 9) < 6);
      in_we       = 1'($urandom_range(0, 1));
      in_size     = 2'($urandom_range(0, 2));
      in_unsigned = 1'($urandom_range(0, 1));
      a           = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << in_size) - 32'd1);
      in_addr           = a;
      in_wdata          = $urandom;
      in_block          = ($urandom_range(0, 9) == 0);
      flush             = ($urandom_range(0, 24) == 0);
      reset             = ($urandom_range(0, 149) == 0);
      data_sram_addr_ok = ($urandom_range(0, 9) < 7);
      data_sram_data_ok = ($urandom_range(0, 9) < 5);
      data_sram_rdata   = $urandom;
      step();
    end

    idle();
    repeat (4) step();
    chk("exp_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
